// File: rtl/bist_sig_analyzer_pkg.sv
// Shared BIST definitions: controller state encoding, default width/seed,
// and the feedback-parity helper used by both the pattern generator and the
// MISR so their tap semantics can never drift apart.
package bist_sig_analyzer_pkg;

  localparam int unsigned BIST_NBIT = 4;
  localparam logic [BIST_NBIT-1:0] BIST_SEED = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

  // Feedback bit: XOR of every register bit whose tap mask bit is set.
  function automatic logic bist_fb(input logic [31:0] val, input logic [31:0] taps);
    return ^(val & taps);
  endfunction

endpackage

// File: rtl/bist_sig_analyzer_misr.sv
// Multiple-input signature register.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, loads SEED
//   clr  : synchronous reload of SEED (higher priority than en)
//   en   : compress resp into the signature this cycle
//   resp : response vector
//   sig  : current signature
module bist_sig_analyzer_misr
  import bist_sig_analyzer_pkg::*;
#(
  parameter int unsigned          NBIT = BIST_NBIT,
  parameter logic [NBIT-1:0]      TAPS = 4'b1100,
  parameter logic [NBIT-1:0]      SEED = BIST_SEED
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [NBIT-1:0] resp,
  output logic [NBIT-1:0] sig
);

  logic [NBIT-1:0] sig_q;
  logic [NBIT-1:0] sig_d;
  logic            fb;

  always_comb begin
    fb    = bist_fb(32'(sig_q), 32'(TAPS));
    sig_d = sig_q;
    if (clr) begin
      sig_d = SEED;
    end else if (en) begin
      // Shift toward the MSB, feedback enters bit 0, then fold in the response.
      sig_d = {sig_q[NBIT-2:0], fb} ^ resp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_sig_analyzer.sv
// BIST response-compaction and sequencing stage.
// Holds the pattern generator in reset, releases it for NPAT patterns while the
// MISR compresses the CUT responses, then compares the signature to GOLDEN.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   start   : begin a run (honoured only in IDLE or DONE)
//   abort   : return to IDLE from any state, clears pass
//   resp    : CUT response vector
//   gen_rst : reset to the pattern generator (high outside RUN)
//   busy    : high in INIT and RUN
//   done    : high in DONE
//   pass    : signature matched GOLDEN (valid while done)
//   sig     : current MISR contents
module bist_sig_analyzer
  import bist_sig_analyzer_pkg::*;
#(
  parameter int unsigned     NBIT   = BIST_NBIT,
  parameter int unsigned     NPAT   = 15,
  parameter logic [NBIT-1:0] TAPS   = 4'b1100,
  parameter logic [NBIT-1:0] SEED   = BIST_SEED,
  parameter logic [NBIT-1:0] GOLDEN = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [NBIT-1:0] resp,
  output logic            gen_rst,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [NBIT-1:0] sig
);

  localparam int unsigned CW = $clog2(NPAT + 1);

  bist_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pass_q, pass_d;
  logic          misr_clr;
  logic          misr_en;

  // State register and run bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    if (abort) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_INIT;
        end
        ST_INIT: begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(NPAT - 1)) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          pass_d  = (sig == GOLDEN);
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (start) state_d = ST_INIT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state; gen_rst therefore follows rst
  // asynchronously through state_q.
  always_comb begin
    gen_rst  = (state_q != ST_RUN);
    busy     = (state_q == ST_INIT) || (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
    misr_clr = (state_q == ST_INIT) && !abort;
    misr_en  = (state_q == ST_RUN) && !abort;
  end

  assign pass = pass_q;

  bist_sig_analyzer_misr #(
    .NBIT (NBIT),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .clr  (misr_clr),
    .en   (misr_en),
    .resp (resp),
    .sig  (sig)
  );

endmodule

// File: tb/tb_bist_sig_analyzer.sv
module tb_bist_sig_analyzer;

  localparam int unsigned NPA    = 4;
  localparam int unsigned NPB    = 15;
  localparam logic [3:0]  SEED_V = 4'b0000;
  localparam logic [3:0]  TAPS_V = 4'b1100;
  localparam logic [3:0]  GOLD_A = 4'b1110;
  localparam logic [3:0]  GOLD_B = 4'b0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start_a, abort_a;
  logic [3:0] resp_a;
  logic       gen_rst_a, busy_a, done_a, pass_a;
  logic [3:0] sig_a;

  logic       start_b, abort_b;
  logic [3:0] resp_b;
  logic       gen_rst_b, busy_b, done_b, pass_b;
  logic [3:0] sig_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bist_sig_analyzer #(
    .NBIT   (4),
    .NPAT   (NPA),
    .TAPS   (TAPS_V),
    .SEED   (SEED_V),
    .GOLDEN (GOLD_A)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .start   (start_a),
    .abort   (abort_a),
    .resp    (resp_a),
    .gen_rst (gen_rst_a),
    .busy    (busy_a),
    .done    (done_a),
    .pass    (pass_a),
    .sig     (sig_a)
  );

  bist_sig_analyzer #(
    .NPAT   (NPB),
    .GOLDEN (GOLD_B)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .start   (start_b),
    .abort   (abort_b),
    .resp    (resp_b),
    .gen_rst (gen_rst_b),
    .busy    (busy_b),
    .done    (done_b),
    .pass    (pass_b),
    .sig     (sig_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signature after the first n responses: shift left, parity of tapped bits
  // enters at the bottom, response XORed in.
  function automatic logic [3:0] misr_ref(input logic [3:0] rs[$], input int unsigned n);
    logic [3:0] s;
    int unsigned ones;
    s = SEED_V;
    for (int unsigned i = 0; i < n; i++) begin
      ones = 0;
      for (int unsigned k = 0; k < 4; k++) begin
        if (TAPS_V[k]) ones += int'(s[k]);
      end
      s = 4'((s * 2) % 16 + (ones % 2)) ^ rs[i];
    end
    return s;
  endfunction

  // Full run on dut_a starting from IDLE or DONE; optional stray start pulses
  // while the run is in progress.
  task automatic run_a(input string tag, input logic [3:0] rs[$], input bit noise);
    logic [3:0] exp_sig;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk({tag, "_init_busy"}, 32'(busy_a), 32'd1);
    chk({tag, "_init_done"}, 32'(done_a), 32'd0);
    chk({tag, "_init_genrst"}, 32'(gen_rst_a), 32'd1);
    tick();
    chk({tag, "_run_genrst"}, 32'(gen_rst_a), 32'd0);
    chk({tag, "_run_seed"}, 32'(sig_a), 32'(SEED_V));
    for (int unsigned i = 0; i < NPA; i++) begin
      resp_a  = rs[i];
      start_a = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      chk({tag, "_sig_step"}, 32'(sig_a), 32'(misr_ref(rs, i + 1)));
      if (i + 1 < NPA) chk({tag, "_run_busy"}, 32'(busy_a), 32'd1);
    end
    start_a = 1'b0;
    resp_a  = 4'($urandom);
    chk({tag, "_check_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_check_done"}, 32'(done_a), 32'd0);
    chk({tag, "_check_genrst"}, 32'(gen_rst_a), 32'd1);
    tick();
    exp_sig = misr_ref(rs, NPA);
    chk({tag, "_done"}, 32'(done_a), 32'd1);
    chk({tag, "_final_sig"}, 32'(sig_a), 32'(exp_sig));
    chk({tag, "_pass"}, 32'(pass_a), 32'(exp_sig == GOLD_A));
  endtask

  // Full run on dut_b, checking done stays low until start+NPB+3.
  task automatic run_b(input string tag, input logic [3:0] rs[$]);
    logic [3:0] exp_sig;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int unsigned c = 1; c <= NPB + 2; c++) begin
      chk({tag, "_done_low"}, 32'(done_b), 32'd0);
      chk({tag, "_busy"}, 32'(busy_b), 32'(c <= NPB + 1));
      if (c >= 2 && c <= NPB + 1) resp_b = rs[c - 2];
      else resp_b = 4'($urandom);
      tick();
    end
    exp_sig = misr_ref(rs, NPB);
    chk({tag, "_done"}, 32'(done_b), 32'd1);
    chk({tag, "_final_sig"}, 32'(sig_b), 32'(exp_sig));
    chk({tag, "_pass"}, 32'(pass_b), 32'(exp_sig == GOLD_B));
  endtask

  initial begin
    logic [3:0] q[$];
    start_a = 1'b0; abort_a = 1'b0; resp_a = '0;
    start_b = 1'b0; abort_b = 1'b0; resp_b = '0;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_genrst", 32'(gen_rst_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_sig", 32'(sig_a), 32'(SEED_V));
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("idle_genrst", 32'(gen_rst_a), 32'd1);

    // Constant 0001 response: 0001, 0011, 0111, 1110.
    q = {};
    repeat (NPA) q.push_back(4'b0001);
    run_a("known", q, 1'b0);
    chk("known_lit_sig", 32'(sig_a), 32'h e);
    chk("known_lit_pass", 32'(pass_a), 32'd1);

    // Abort in RUN cycle 2 with a simultaneous start; abort must win.
    q = {};
    repeat (NPA) q.push_back(4'($urandom));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    resp_a = q[0];
    tick();
    resp_a  = q[1];
    abort_a = 1'b1;
    start_a = 1'b1;
    tick();
    abort_a = 1'b0;
    start_a = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_pass", 32'(pass_a), 32'd0);
    chk("abort_genrst", 32'(gen_rst_a), 32'd1);
    chk("abort_sig_hold", 32'(sig_a), 32'(misr_ref(q, 1)));
    tick();
    chk("abort_stay_idle", 32'(busy_a), 32'd0);
    run_a("after_abort", q, 1'b1);

    // Restart straight from DONE; fault in the third response.
    q = {};
    repeat (NPA) q.push_back(4'b0001);
    q[2] = 4'b0000;
    run_a("fault", q, 1'b1);
    chk("fault_lit_sig", 32'(sig_a), 32'h c);
    chk("fault_lit_pass", 32'(pass_a), 32'd0);

    for (int r = 0; r < 5; r++) begin
      q = {};
      repeat (NPA) q.push_back(4'($urandom));
      run_a("rand", q, 1'b1);
    end

    // Passing run, then asynchronous reset in the middle of the next run.
    q = {};
    repeat (NPA) q.push_back(4'b0001);
    run_a("pre_rst", q, 1'b0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    resp_a = 4'b0101;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_genrst", 32'(gen_rst_a), 32'd1);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_done", 32'(done_a), 32'd0);
    chk("midrst_pass", 32'(pass_a), 32'd0);
    chk("midrst_sig", 32'(sig_a), 32'(SEED_V));
    #2 rst = 1'b0;
    tick();
    chk("postrst_idle", 32'(busy_a), 32'd0);

    // Default-parameter instance: all-zero responses, then random.
    q = {};
    repeat (NPB) q.push_back(4'b0000);
    run_b("zero", q);
    chk("zero_lit_sig", 32'(sig_b), 32'd0);
    chk("zero_lit_pass", 32'(pass_b), 32'd1);
    for (int r = 0; r < 2; r++) begin
      q = {};
      repeat (NPB) q.push_back(4'($urandom));
      run_b("rand_b", q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
